// File: rtl/sevenseg_word_decoder.sv
// Recovers the hex word shown on an active-low multi-digit 7-segment bus.
// Waits for a stable bus, then decodes one digit per clock and strobes the result.
module sevenseg_word_decoder #(
  parameter int HEX_DIGITS     = 8,
  parameter int SEGS_PER_DIGIT = 7,
  parameter int STABLE_CYCLES  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [HEX_DIGITS*SEGS_PER_DIGIT-1:0] seg_in,
  output logic [4*HEX_DIGITS-1:0]            word_out,
  output logic                               word_valid,
  output logic [HEX_DIGITS-1:0]              digit_err,
  output logic                               err_sticky,
  output logic                               busy
);

  localparam int SW  = HEX_DIGITS * SEGS_PER_DIGIT;
  localparam int WW  = 4 * HEX_DIGITS;
  localparam int NIB = 4;
  localparam int IW  = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;
  localparam int CW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(HEX_DIGITS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, DECODE = 1'b1} state_t;

  // Returns {error, nibble}; blank and any non-hex shape decode to 0 with error set.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg_n);
    logic [4:0] r;
    r = {1'b1, 4'h0};
    case (~seg_n)
      7'b1111110: r = {1'b0, 4'h0};
      7'b0110000: r = {1'b0, 4'h1};
      7'b1101101: r = {1'b0, 4'h2};
      7'b1111001: r = {1'b0, 4'h3};
      7'b0110011: r = {1'b0, 4'h4};
      7'b1011011: r = {1'b0, 4'h5};
      7'b1011111: r = {1'b0, 4'h6};
      7'b1110000: r = {1'b0, 4'h7};
      7'b1111111: r = {1'b0, 4'h8};
      7'b1111011: r = {1'b0, 4'h9};
      7'b1110111: r = {1'b0, 4'hA};
      7'b0011111: r = {1'b0, 4'hB};
      7'b1001110: r = {1'b0, 4'hC};
      7'b0111101: r = {1'b0, 4'hD};
      7'b1001111: r = {1'b0, 4'hE};
      7'b1000111: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  state_t                state_r, next_state_s;
  logic [SW-1:0]         samp_r, shadow_r, last_snap_r;
  logic [CW-1:0]         cnt_r;
  logic                  first_flag_r;
  logic [IW-1:0]         idx_r;
  logic [WW-1:0]         acc_r, acc_next_s, word_r;
  logic [HEX_DIGITS-1:0] err_acc_r, err_next_s, digit_err_r;
  logic                  valid_r, sticky_r, busy_r;
  logic                  capture_s, last_s;
  logic [4:0]            digit_dec_s;

  // Next-state, capture decision and per-digit accumulation.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    last_s       = 1'b0;
    digit_dec_s  = decode_digit(shadow_r[idx_r*SEGS_PER_DIGIT +: 7]);
    acc_next_s   = acc_r;
    err_next_s   = err_acc_r;
    acc_next_s[idx_r*NIB +: NIB] = digit_dec_s[3:0];
    err_next_s[idx_r]            = digit_dec_s[4];
    case (state_r)
      IDLE: begin
        if ((cnt_r == CNT_MAX) && (seg_in == samp_r) &&
            ((samp_r != last_snap_r) || first_flag_r)) begin
          capture_s    = 1'b1;
          next_state_s = DECODE;
        end else begin
          next_state_s = IDLE;
        end
      end
      DECODE: begin
        if (idx_r == IDX_LAST) begin
          last_s       = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = DECODE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Input stabiliser, snapshot capture and published results.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_r       <= '0;
      cnt_r        <= '0;
      shadow_r     <= '0;
      last_snap_r  <= '0;
      first_flag_r <= 1'b1;
      idx_r        <= '0;
      acc_r        <= '0;
      err_acc_r    <= '0;
      word_r       <= '0;
      digit_err_r  <= '0;
      valid_r      <= 1'b0;
      sticky_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      samp_r  <= seg_in;
      valid_r <= 1'b0;
      busy_r  <= (next_state_s == DECODE);
      if (seg_in != samp_r)    cnt_r <= '0;
      else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + 1'b1;
      if (capture_s) begin
        shadow_r     <= samp_r;
        last_snap_r  <= samp_r;
        first_flag_r <= 1'b0;
        idx_r        <= '0;
        acc_r        <= '0;
        err_acc_r    <= '0;
      end else if (state_r == DECODE) begin
        acc_r     <= acc_next_s;
        err_acc_r <= err_next_s;
        idx_r     <= idx_r + 1'b1;
        if (last_s) begin
          word_r      <= acc_next_s;
          digit_err_r <= err_next_s;
          sticky_r    <= sticky_r | (|err_next_s);
          valid_r     <= 1'b1;
        end
      end
    end
  end

  assign word_out   = word_r;
  assign word_valid = valid_r;
  assign digit_err  = digit_err_r;
  assign err_sticky = sticky_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_sevenseg_word_decoder.sv
// Scoreboard bench for sevenseg_word_decoder: expected words and strobe cycles
// are queued when stimulus is driven and compared whenever word_valid fires.
module tb_sevenseg_word_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [55:0] seg_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic [7:0]  digit_err;
  logic        err_sticky;
  logic        busy;

  sevenseg_word_decoder #(
    .HEX_DIGITS(8), .SEGS_PER_DIGIT(7), .STABLE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .word_out(word_out),
    .word_valid(word_valid), .digit_err(digit_err), .err_sticky(err_sticky),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  e;
    logic        s;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc_digit(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1111110; 4'h1: p = 7'b0110000; 4'h2: p = 7'b1101101; 4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011; 4'h5: p = 7'b1011011; 4'h6: p = 7'b1011111; 4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111; 4'h9: p = 7'b1111011; 4'hA: p = 7'b1110111; 4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110; 4'hD: p = 7'b0111101; 4'hE: p = 7'b1001111; default: p = 7'b1000111;
    endcase
    return ~p;
  endfunction

  function automatic logic [55:0] enc_word(input logic [31:0] w);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = enc_digit(w[i*4 +: 4]);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [7:0] e, input logic s, input int c);
    exp_t x;
    x.w = w; x.e = e; x.s = s; x.c = c;
    sb.push_back(x);
  endtask

  // Every strobe must match the oldest pending expectation, including its cycle.
  always @(negedge clk) begin
    if (word_valid) begin
      check_eq("strobe_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        check_eq("word_out", 64'(word_out), 64'(x.w));
        check_eq("digit_err", 64'(digit_err), 64'(x.e));
        check_eq("err_sticky", 64'(err_sticky), 64'(x.s));
        check_eq("strobe_cycle", 64'(cyc), 64'(x.c));
      end
    end
  end

  initial begin
    int n;
    int r;
    int busy_seen;
    int guard;
    logic [55:0] sv;

    reset  = 1'b1;
    seg_in = enc_word(32'h0);
    tick(3);
    check_eq("rst_word", 64'(word_out), 64'd0);
    check_eq("rst_valid", 64'(word_valid), 64'd0);
    check_eq("rst_err", 64'(digit_err), 64'd0);
    check_eq("rst_sticky", 64'(err_sticky), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // First word after reset: strobe 13 cycles after it appears.
    reset  = 1'b0;
    seg_in = enc_word(32'h0123ABCD);
    n = cyc;
    push(32'h0123ABCD, 8'h00, 1'b0, n + 13);
    tick(14);
    check_eq("t1_drained", 64'(sb.size()), 64'd0);

    // Static display: no re-capture, no busy.
    busy_seen = 0;
    repeat (200) begin
      tick(1);
      busy_seen += int'(busy);
    end
    check_eq("static_busy", 64'(busy_seen), 64'd0);

    // Flicker on digit 0 shorter than the stability window, ending on the old value.
    for (int k = 0; k < 10; k++) begin
      seg_in = enc_word((k % 2 == 0) ? 32'h0123ABC5 : 32'h0123ABCD);
      tick(3);
    end
    check_eq("flicker_quiet", 64'(sb.size()), 64'd0);
    seg_in = enc_word(32'h0123ABC5);
    n = cyc;
    push(32'h0123ABC5, 8'h00, 1'b0, n + 13);
    tick(14);
    check_eq("t3_drained", 64'(sb.size()), 64'd0);

    // Blank digit 2 flags an error; sticky survives the next clean word.
    sv = enc_word(32'h77777777);
    sv[2*7 +: 7] = 7'h7F;
    seg_in = sv;
    n = cyc;
    push(32'h77777077, 8'h04, 1'b1, n + 13);
    tick(14);
    seg_in = enc_word(32'h77777777);
    n = cyc;
    push(32'h77777777, 8'h00, 1'b1, n + 13);
    tick(14);

    // Input changes mid-decode: decode finishes, new value captured when IDLE returns.
    seg_in = enc_word(32'h12345678);
    n = cyc;
    push(32'h12345678, 8'h00, 1'b1, n + 13);
    push(32'hFFFFFFFF, 8'h00, 1'b1, n + 22);
    tick(7);
    seg_in = enc_word(32'hFFFFFFFF);
    tick(16);
    check_eq("t5_drained", 64'(sb.size()), 64'd0);

    // Reset during decode aborts it; same value is captured again after release.
    seg_in = enc_word(32'h89ABCDEF);
    n = cyc;
    tick(7);
    check_eq("t6_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    r = cyc;
    tick(1);
    reset = 1'b0;
    check_eq("t6_word", 64'(word_out), 64'd0);
    check_eq("t6_valid", 64'(word_valid), 64'd0);
    check_eq("t6_err", 64'(digit_err), 64'd0);
    check_eq("t6_sticky", 64'(err_sticky), 64'd0);
    check_eq("t6_busy_clr", 64'(busy), 64'd0);
    push(32'h89ABCDEF, 8'h00, 1'b0, r + 14);
    tick(14);

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sevenseg_word_decoder.md
Name: sevenseg_word_decoder

Overview:
- Reads back a multi-digit 7-segment hex display bus (active-low segments, 7 wires per digit, no decimal points) and recovers the hex word it displays.
- Waits for the segment bus to be stable, then decodes one digit per clock.
- Publishes the recovered word with a one-cycle valid strobe and per-digit error flags.
- Used as an on-chip self-check of the display path and as a bench monitor for it.

Parameters:
- HEX_DIGITS, 8: number of digits; word width is 4*HEX_DIGITS.
- SEGS_PER_DIGIT, 7: segment wires per digit; fixed at 7 for the decode table.
- STABLE_CYCLES, 4: consecutive identical samples required before capture; minimum 1.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high reset.
- seg_in, input, HEX_DIGITS*SEGS_PER_DIGIT: active-low segment bus. Digit i occupies bits [7i+6:7i]; within a digit, bit6=a ... bit0=g.
- word_out, output, 4*HEX_DIGITS: last decoded word; digit i maps to nibble [4i+3:4i].
- word_valid, output, 1: one-cycle strobe when word_out/digit_err update.
- digit_err, output, HEX_DIGITS: bit i set if digit i held a non-hex pattern in the last published word.
- err_sticky, output, 1: set on any digit error; cleared only by reset.
- busy, output, 1: high while in DECODE.

Behaviour:
- Reset: word_out=0, word_valid=0, digit_err=0, err_sticky=0, busy=0. Internally: state=IDLE, stability counter=0, sample register=0, first_flag=1.
- Input stage: seg_in is registered every cycle into samp. If seg_in != samp, the counter clears to 0; otherwise it increments, saturating at STABLE_CYCLES-1.
- Decode table (active-high pattern = ~segments): 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000, 8:1111111, 9:1111011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111. Any other pattern (including blank) decodes to nibble 0 and sets the error bit for that digit.
- FSM IDLE:
  - Capture when counter==STABLE_CYCLES-1 and seg_in==samp and (samp != last_snap or first_flag).
  - On capture: shadow<=samp, last_snap<=samp, first_flag<=0, idx<=0, go to DECODE.
  - Otherwise stay in IDLE.
- FSM DECODE (busy=1):
  - Each cycle, decode shadow digit idx into an accumulator nibble and error bit, then idx++.
  - In the cycle idx==HEX_DIGITS-1, on that edge: word_out<=accumulated word, digit_err<=error bits, err_sticky|=|error bits, word_valid<=1; return to IDLE.
- word_valid is registered, high for exactly one cycle, then 0.
- Latency: take the first cycle seg_in presents a new value as cycle 0, with the value held thereafter. word_valid is high in cycle STABLE_CYCLES+HEX_DIGITS+1 (cycle 13 at defaults).
- seg_in changes during DECODE: decoding uses shadow and is unaffected. The counter tracks the new value and a new capture may occur in IDLE once it is stable.
- A value that is stable but equal to the last captured snapshot is never re-captured; no repeated strobes for a static display.
- Flicker shorter than STABLE_CYCLES never causes a capture. Returning to the last captured value after flicker produces no strobe.
- Reset during DECODE: aborts, no strobe, all outputs return to reset values. The first stable value after reset is captured even if it equals the pre-reset snapshot.
- Capture is never back-to-back: a capture can occur at the earliest in the cycle word_valid is high.

Test Plan:
- Reset, then hold seg_in = encoding of 0x0123ABCD -> word_valid high in cycle 13 only; word_out=0x0123ABCD; digit_err=0x00; err_sticky=0.
- Hold the same value 200 further cycles -> no further word_valid; busy stays 0.
- Toggle digit 0 between encodings of D and 5 every 3 cycles for 30 cycles, then hold 5 -> no strobe while toggling; single strobe with word_out=0x0123ABC5 in cycle 13 after the final change.
- Digit 2 blank (seg bits all 1) and others show 7 -> word_out=0x77777077, digit_err=0x04, err_sticky=1. Next clean word gives digit_err=0x00 with err_sticky still 1.
- Change seg_in to 0xFFFFFFFF encoding at the 3rd DECODE cycle of a 0x12345678 capture -> first strobe word_out=0x12345678, second strobe later with 0xFFFFFFFF.
- Assert reset for 1 cycle during DECODE cycle 3 with a constant input -> no strobe from the aborted decode, outputs 0. Same value re-captured and strobed 13 cycles after reset release.
